// File: rtl/soc_system_aes_ram_sequencer.sv
// -----------------------------------------------------------------------------
// soc_system_aes_ram_sequencer
//
// Walks a small data RAM (4 x 128-bit words) through an external AES core.
// Word 0 holds the key and words 1..3 hold plaintext blocks. One batch:
//   - fetch the key once and hand it to the core (aes_key + aes_key_load),
//   - for each block: read it, present it on a valid/ready handshake, wait
//     for the core's one-cycle result pulse, write the result back in place.
// The key word is only ever read, never written.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start, block_count  batch request; block_count (0..3) sampled with start
//   busy, done          busy from accepted start through the done pulse
//   mem_*               RAM master; read data returns one cycle after strobe
//   aes_key/_key_load   key register and its one-cycle update pulse
//   aes_in_*            block to the core (valid/ready)
//   aes_out_*           result from the core (one-cycle valid pulse)
// -----------------------------------------------------------------------------
module soc_system_aes_ram_sequencer (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   block_count,
  output logic         busy,
  output logic         done,
  output logic [1:0]   mem_address,
  output logic         mem_chipselect,
  output logic         mem_write,
  output logic [15:0]  mem_byteenable,
  output logic [127:0] mem_writedata,
  input  logic [127:0] mem_readdata,
  output logic [127:0] aes_key,
  output logic         aes_key_load,
  output logic         aes_in_valid,
  input  logic         aes_in_ready,
  output logic [127:0] aes_in_data,
  input  logic         aes_out_valid,
  input  logic [127:0] aes_out_data
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_RD_KEY   = 4'd1;
  localparam logic [3:0] S_LD_KEY   = 4'd2;
  localparam logic [3:0] S_RD_BLK   = 4'd3;
  localparam logic [3:0] S_CAP_BLK  = 4'd4;
  localparam logic [3:0] S_SEND     = 4'd5;
  localparam logic [3:0] S_WAIT_RES = 4'd6;
  localparam logic [3:0] S_WR_BLK   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [1:0]   KEY_ADDR   = 2'd0;
  localparam logic [1:0]   FIRST_BLK  = 2'd1;
  localparam logic [15:0]  ALL_BYTES  = 16'hFFFF;

  logic [3:0]   state_q, state_d;
  logic [1:0]   count_q, count_d;
  logic [1:0]   idx_q,   idx_d;
  logic [127:0] key_q,   key_d;
  logic [127:0] blk_q,   blk_d;
  logic [127:0] res_q,   res_d;

  // ---------------------------------------------------------------------------
  // Next-state and datapath-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    key_d   = key_q;
    blk_d   = blk_q;
    res_d   = res_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (block_count != 2'd0) begin
            state_d = S_RD_KEY;
            count_d = block_count;
            idx_d   = FIRST_BLK;
          end else begin
            // Empty batch: acknowledge without touching RAM or the key.
            state_d = S_DONE;
          end
        end
      end

      S_RD_KEY: state_d = S_LD_KEY;

      S_LD_KEY: begin
        // Read data for the RD_KEY strobe is valid in this cycle.
        key_d   = mem_readdata;
        state_d = S_RD_BLK;
      end

      S_RD_BLK: state_d = S_CAP_BLK;

      S_CAP_BLK: begin
        blk_d   = mem_readdata;
        state_d = S_SEND;
      end

      S_SEND: begin
        // blk_q is untouched here, so aes_in_data stays stable while stalled.
        if (aes_in_ready) state_d = S_WAIT_RES;
      end

      S_WAIT_RES: begin
        if (aes_out_valid) begin
          res_d   = aes_out_data;
          state_d = S_WR_BLK;
        end
      end

      S_WR_BLK: begin
        if (idx_q == count_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_RD_BLK;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers (every register has a defined reset value)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 2'd0;
      idx_q   <= 2'd0;
      key_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: control strobes are pure functions of the current state, so
  // they drop the same edge reset forces IDLE.
  // ---------------------------------------------------------------------------
  logic st_rd_key, st_rd_blk, st_wr_blk;

  assign st_rd_key = (state_q == S_RD_KEY);
  assign st_rd_blk = (state_q == S_RD_BLK);
  assign st_wr_blk = (state_q == S_WR_BLK);

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign mem_chipselect = st_rd_key | st_rd_blk | st_wr_blk;
  assign mem_write      = st_wr_blk;
  // Block accesses use idx; the key read and all idle cycles show address 0.
  assign mem_address    = (st_rd_blk | st_wr_blk) ? idx_q : KEY_ADDR;
  assign mem_byteenable = mem_chipselect ? ALL_BYTES : 16'h0000;
  assign mem_writedata  = res_q;
  assign aes_key        = key_q;
  assign aes_key_load   = (state_q == S_LD_KEY);
  assign aes_in_valid   = (state_q == S_SEND);
  assign aes_in_data    = blk_q;

endmodule

// File: tb/tb_soc_system_aes_ram_sequencer.sv
module tb_soc_system_aes_ram_sequencer;

  localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] P3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam int           RES_LAT = 10;

  logic         clk = 1'b0;
  logic         reset, start, aes_in_ready;
  logic [1:0]   block_count;
  logic         busy, done, mem_chipselect, mem_write, aes_key_load, aes_in_valid;
  logic [1:0]   mem_address;
  logic [15:0]  mem_byteenable;
  logic [127:0] mem_writedata, mem_readdata, aes_key, aes_in_data, aes_out_data;
  logic         aes_out_valid;

  int checks = 0;
  int errors = 0;

  // environment bookkeeping (written only by the env process)
  logic [127:0] mem [4];
  logic [1:0]   wr_addr [16];
  int n_wr = 0, n_wr0 = 0, n_cs = 0, n_keyload = 0, n_done = 0, n_rule_bad = 0, n_xfer = 0;

  // preload request (written only by the main process)
  logic [127:0] init_words [4];
  int load_seq = 0;

  always #5 clk = ~clk;

  soc_system_aes_ram_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .block_count(block_count),
    .busy(busy), .done(done), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .aes_key(aes_key), .aes_key_load(aes_key_load),
    .aes_in_valid(aes_in_valid), .aes_in_ready(aes_in_ready), .aes_in_data(aes_in_data),
    .aes_out_valid(aes_out_valid), .aes_out_data(aes_out_data)
  );

  // RAM + AES core model: sample DUT at negedge, apply effects just after posedge.
  initial begin : env
    int cnt;
    int last_seq;
    logic [127:0] res;
    logic s_cs, s_we, s_iv, s_ir;
    logic [1:0] s_addr;
    logic [127:0] s_wd, s_id;
    cnt = 0; last_seq = 0; res = '0;
    mem_readdata = 128'hBADBADBADBADBADBADBADBADBADBAD00;
    aes_out_valid = 1'b0;
    aes_out_data = '0;
    for (int i = 0; i < 4; i++) mem[i] = '0;
    forever begin
      @(negedge clk);
      s_cs = mem_chipselect; s_we = mem_write; s_addr = mem_address; s_wd = mem_writedata;
      s_iv = aes_in_valid; s_ir = aes_in_ready; s_id = aes_in_data;
      if (s_cs === 1'b1) n_cs++;
      if (s_cs === 1'b1 && mem_byteenable !== 16'hFFFF) n_rule_bad++;
      if (s_we === 1'b1 && s_cs !== 1'b1) n_rule_bad++;
      if (aes_key_load === 1'b1) n_keyload++;
      if (done === 1'b1) n_done++;
      if (s_iv === 1'b1 && s_ir === 1'b1) n_xfer++;
      if (s_cs === 1'b1 && s_we === 1'b1) begin
        if (n_wr < 16) wr_addr[n_wr] = s_addr;
        n_wr++;
        if (s_addr == 2'd0) n_wr0++;
      end
      @(posedge clk);
      #1;
      if (load_seq != last_seq) begin
        last_seq = load_seq;
        for (int i = 0; i < 4; i++) mem[i] = init_words[i];
      end
      if (s_cs === 1'b1 && s_we === 1'b1) mem[s_addr] = s_wd;
      if (s_cs === 1'b1 && s_we === 1'b0) mem_readdata = mem[s_addr];
      else mem_readdata = 128'hBADBADBADBADBADBADBADBADBADBAD00;
      aes_out_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          aes_out_valid = 1'b1;
          aes_out_data = res;
        end
      end
      if (s_iv === 1'b1 && s_ir === 1'b1) begin
        cnt = RES_LAT;
        res = s_id ^ K;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic load_ram();
    init_words[0] = K; init_words[1] = P1; init_words[2] = P2; init_words[3] = P3;
    load_seq++;
    cyc();
  endtask

  task automatic do_start(input logic [1:0] bc);
    block_count = bc;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if ({busy, done, mem_chipselect, mem_write, mem_address, mem_byteenable, aes_key_load, aes_in_valid} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b cs=%b we=%b addr=%0d be=%h kl=%b iv=%b required all 0",
               busy, done, mem_chipselect, mem_write, mem_address, mem_byteenable, aes_key_load, aes_in_valid);
    end
    checks++;
    if ({aes_key, aes_in_data, mem_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_data got key=%h in=%h wd=%h required 0", aes_key, aes_in_data, mem_writedata);
    end
    reset = 1'b0;
    cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy got %b required 0", busy);
    end
  endtask

  task automatic test_full_batch();
    int n; bit ok; int d0, w0, wr00, kl0, rb0;
    load_ram();
    d0 = n_done; w0 = n_wr; wr00 = n_wr0; kl0 = n_keyload; rb0 = n_rule_bad;
    do_start(2'd3);
    wait_done(300, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_done_timeout got no done required done within 300 cycles");
    end
    checks++;
    if (n != 2 + 3 * (5 + RES_LAT)) begin
      errors++;
      $display("FAIL full_latency got %0d cycles required %0d", n, 2 + 3 * (5 + RES_LAT));
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_done got %b required 1", busy);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done got busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (mem[1] !== (P1 ^ K) || mem[2] !== (P2 ^ K) || mem[3] !== (P3 ^ K)) begin
      errors++;
      $display("FAIL full_ram got %h %h %h required %h %h %h", mem[1], mem[2], mem[3], P1 ^ K, P2 ^ K, P3 ^ K);
    end
    checks++;
    if (mem[0] !== K || n_wr0 != wr00) begin
      errors++;
      $display("FAIL key_word got %h (writes to 0: %0d) required %h (0)", mem[0], n_wr0 - wr00, K);
    end
    checks++;
    if (aes_key !== K) begin
      errors++;
      $display("FAIL aes_key got %h required %h", aes_key, K);
    end
    checks++;
    if (n_done - d0 != 1 || n_wr - w0 != 3 || n_keyload - kl0 != 1) begin
      errors++;
      $display("FAIL full_counts got done=%0d wr=%0d keyload=%0d required 1 3 1", n_done - d0, n_wr - w0, n_keyload - kl0);
    end
    checks++;
    if (n_rule_bad != rb0) begin
      errors++;
      $display("FAIL bus_rules got %0d violations required 0", n_rule_bad - rb0);
    end
  endtask

  task automatic test_zero_blocks();
    int cs0, kl0;
    cs0 = n_cs; kl0 = n_keyload;
    do_start(2'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b required 1 1", done, busy);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_end got done=%b busy=%b required 0 0", done, busy);
    end
    cyc();
    checks++;
    if (n_cs != cs0 || n_keyload != kl0) begin
      errors++;
      $display("FAIL zero_no_access got cs=%0d keyload=%0d required 0 0", n_cs - cs0, n_keyload - kl0);
    end
  endtask

  task automatic test_stall();
    int n; bit ok; int x0; bit bad; logic [127:0] d;
    load_ram();
    aes_in_ready = 1'b0;
    x0 = n_xfer;
    do_start(2'd1);
    n = 0;
    while (aes_in_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    d = aes_in_data;
    checks++;
    if (aes_in_valid !== 1'b1 || d !== P1) begin
      errors++;
      $display("FAIL stall_present got valid=%b data=%h required 1 %h", aes_in_valid, d, P1);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (aes_in_valid !== 1'b1 || aes_in_data !== d) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stall_hold got unstable valid/data required held for 20 cycles");
    end
    aes_in_ready = 1'b1;
    cyc();
    checks++;
    if (aes_in_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got valid=%b required 0", aes_in_valid);
    end
    wait_done(100, n, ok);
    cyc();
    checks++;
    if (!ok || n_xfer - x0 != 1 || mem[1] !== (P1 ^ K)) begin
      errors++;
      $display("FAIL stall_result got done=%b xfers=%0d word1=%h required 1 1 %h", ok, n_xfer - x0, mem[1], P1 ^ K);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit ok; int d0, w0;
    load_ram();
    d0 = n_done; w0 = n_wr;
    do_start(2'd1);
    cyc(); cyc();
    do_start(2'd3);
    wait_done(100, n, ok);
    for (int i = 0; i < 60; i++) cyc();
    checks++;
    if (!ok || n_done - d0 != 1 || n_wr - w0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got done_seen=%b dones=%0d writes=%0d busy=%b required 1 1 1 0",
               ok, n_done - d0, n_wr - w0, busy);
    end
    checks++;
    if (mem[2] !== P2 || mem[3] !== P3) begin
      errors++;
      $display("FAIL back_to_back_ram got %h %h required %h %h", mem[2], mem[3], P2, P3);
    end
  endtask

  task automatic test_reset_mid();
    int n; int w0;
    load_ram();
    w0 = n_wr;
    do_start(2'd1);
    n = 0;
    while (aes_in_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    cyc();
    checks++;
    if (busy !== 1'b1 || aes_in_valid !== 1'b0 || aes_key !== K) begin
      errors++;
      $display("FAIL reach_wait_res got busy=%b valid=%b key=%h required 1 0 %h", busy, aes_in_valid, aes_key, K);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if ({busy, done, mem_chipselect, mem_write, mem_address, mem_byteenable, aes_key_load, aes_in_valid} !== '0
        || {aes_key, aes_in_data, mem_writedata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_values got busy=%b cs=%b key=%h in=%h wd=%h required all 0",
               busy, mem_chipselect, aes_key, aes_in_data, mem_writedata);
    end
    for (int i = 0; i < 15; i++) cyc();
    checks++;
    if (n_wr != w0 || busy !== 1'b0 || mem[1] !== P1) begin
      errors++;
      $display("FAIL late_result got writes=%0d busy=%b word1=%h required 0 0 %h", n_wr - w0, busy, mem[1], P1);
    end
  endtask

  task automatic test_two_blocks();
    int n; bit ok; int w0, kl0;
    load_ram();
    w0 = n_wr; kl0 = n_keyload;
    do_start(2'd2);
    wait_done(200, n, ok);
    cyc();
    checks++;
    if (!ok || n_wr - w0 != 2) begin
      errors++;
      $display("FAIL two_writes got done=%b writes=%0d required 1 2", ok, n_wr - w0);
    end
    checks++;
    if (wr_addr[w0] !== 2'd1 || wr_addr[w0 + 1] !== 2'd2) begin
      errors++;
      $display("FAIL two_order got %0d,%0d required 1,2", wr_addr[w0], wr_addr[w0 + 1]);
    end
    checks++;
    if (mem[1] !== (P1 ^ K) || mem[2] !== (P2 ^ K) || mem[3] !== P3 || mem[0] !== K) begin
      errors++;
      $display("FAIL two_ram got %h %h %h %h required %h %h %h %h",
               mem[0], mem[1], mem[2], mem[3], K, P1 ^ K, P2 ^ K, P3);
    end
    checks++;
    if (n_keyload - kl0 != 1) begin
      errors++;
      $display("FAIL two_keyload got %0d required 1", n_keyload - kl0);
    end
  endtask

  initial begin : main
    reset = 1'b1;
    start = 1'b0;
    block_count = 2'd0;
    aes_in_ready = 1'b1;
    for (int i = 0; i < 4; i++) init_words[i] = '0;
    test_reset();
    test_full_batch();
    test_zero_blocks();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_two_blocks();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_system_aes_ram_sequencer.md
SOC_SYSTEM_AES_RAM_SEQUENCER -- requirements
Module: soc_system_aes_ram_sequencer

Interface
REQ-001 SHALL have no parameters; data RAM geometry is fixed at 4 words x 128 bits, word 0 = key, words 1..3 = blocks.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to process a batch.
REQ-005 block_count  input  2  number of blocks (0..3), sampled with start.
REQ-006 busy  output  1  high from accepted start until done pulse inclusive.
REQ-007 done  output  1  one-cycle pulse at batch completion.
REQ-008 mem_address  output  2  data RAM word address.
REQ-009 mem_chipselect  output  1  RAM access strobe.
REQ-010 mem_write  output  1  write qualifier (with mem_chipselect).
REQ-011 mem_byteenable  output  16  byte enables.
REQ-012 mem_writedata  output  128  write data.
REQ-013 mem_readdata  input  128  RAM read data, valid exactly 1 cycle after a read strobe.
REQ-014 aes_key  output  128  key register to AES core.
REQ-015 aes_key_load  output  1  one-cycle pulse when aes_key updates.
REQ-016 aes_in_valid / aes_in_ready / aes_in_data  out/in/out  1/1/128  block to AES core, valid/ready handshake.
REQ-017 aes_out_valid / aes_out_data  input  1/128  result from AES core; aes_out_valid is a one-cycle pulse.

Function
REQ-018 States SHALL be IDLE, RD_KEY, LD_KEY, RD_BLK, CAP_BLK, SEND, WAIT_RES, WR_BLK, DONE.
REQ-019 IDLE: start=1, block_count!=0 -> RD_KEY, latch count, idx=1; start=1, block_count=0 -> DONE with no RAM access; start while not IDLE SHALL be ignored.
REQ-020 RD_KEY: mem_address=0, mem_chipselect=1, mem_write=0 for one cycle -> LD_KEY.
REQ-021 LD_KEY: aes_key <= mem_readdata, aes_key_load=1 this cycle -> RD_BLK.
REQ-022 RD_BLK: read strobe at mem_address=idx -> CAP_BLK; CAP_BLK: aes_in_data <= mem_readdata -> SEND.
REQ-023 SEND: aes_in_valid=1, aes_in_data held stable until aes_in_ready=1; transfer completes in the cycle both are high -> WAIT_RES.
REQ-024 WAIT_RES: wait indefinitely; on aes_out_valid=1 capture aes_out_data into mem_writedata -> WR_BLK; aes_out_valid in any other state SHALL be ignored.
REQ-025 WR_BLK: one-cycle write, mem_address=idx, mem_chipselect=1, mem_write=1, mem_byteenable=16'hFFFF; if idx==count -> DONE, else idx+1 -> RD_BLK.
REQ-026 DONE: done=1 for one cycle -> IDLE.
REQ-027 mem_chipselect SHALL be 0 outside RD_KEY, RD_BLK, WR_BLK; mem_write SHALL be 1 only in WR_BLK; mem_byteenable SHALL be 16'hFFFF whenever mem_chipselect=1.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 Blocks SHALL be written back in place (ciphertext overwrites plaintext at the same address); key word 0 SHALL never be written.
REQ-030 Per-block latency with immediate aes_in_ready and result N cycles after transfer SHALL be 5+N cycles; key fetch adds 2 cycles once per batch.

Reset
REQ-031 reset=1 at a clk edge SHALL force IDLE from any state, including mid-handshake or mid-write.
REQ-032 Reset values: busy=0, done=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0, aes_key=0, aes_key_load=0, aes_in_valid=0, aes_in_data=0, latched count=0, idx=0.
REQ-033 A result pulse arriving after reset SHALL NOT cause a RAM write.

Verification
REQ-034 RAM model word0=K, words1..3=P1..P3; start, block_count=3, core returns data XOR K after 10 cycles -> words1..3=Pi^K, word0 unchanged, done pulse once, busy low after it.
REQ-035 start with block_count=0 -> done pulse 1 cycle later, no mem_chipselect activity, aes_key_load never asserted.
REQ-036 aes_in_ready held low 20 cycles in SEND -> aes_in_valid stays 1 and aes_in_data constant; single transfer when ready rises.
REQ-037 second start while busy (block_count=1 then 3) -> only one block processed, exactly one done.
REQ-038 reset asserted in WAIT_RES, then aes_out_valid pulses -> all outputs at reset values, no RAM write, next start runs normally.
REQ-039 block_count=2 -> exactly two writes (addresses 1 then 2), word3 untouched, aes_key_load pulses exactly once.
